motoro3_step_scheduler: RTL and testbench
=========================================

# motoro3_step_scheduler

Commutation-step scheduler for the motoro3 three-phase PWM path. It generates the per-step sub-counter `m3cnt`, the step-boundary strobes `m3cntFirst1/2` and `m3cntLast1/2`, and the commutation index `sgStep`. It also produces a ramped pulse-length command `plLen`, and all of these outputs feed `motoro3_pwm_generator` directly. Run, stop and ramping are controlled by register-file inputs (`m3r_*`), and configuration is shadowed so that changes take effect only at step boundaries.

## Interface
- `CNT_W`, default 25: width of `m3cnt` and `m3r_stepLen`.
- `clk`  in  1: 10 MHz system clock; all flops update on the falling edge.
- `rst`  in  1: asynchronous, active-high reset.
- `m3r_run`  in  1: level; 1 requests RUN, 0 requests STOP.
- `m3r_stepLen`  in  CNT_W: clocks per commutation step; values below 4 are treated as 4.
- `m3r_stepMax`  in  4: index of the last step; values of 14 or 15 are treated as 14, because 15 is reserved as the idle marker.
- `m3r_plLenTarget`  in  16: target pulse length.
- `m3r_plLenRamp`  in  16: maximum `plLen` change per step; 0 means jump to target.
- `pwmActive1`  out  1: 1 whenever state is not IDLE.
- `m3cnt`  out  CNT_W: position within the current step.
- `m3cntFirst1`  out  1: high when `m3cnt`==0 in RUN or STOP.
- `m3cntFirst2`  out  1: high when `m3cnt`==1.
- `m3cntLast2`  out  1: high when `m3cnt`==len-2.
- `m3cntLast1`  out  1: high when `m3cnt`==len-1, the step's final clock.
- `sgStep`  out  4: commutation index 0..stepMax; reads 15 in IDLE.
- `plLen`  out  16: pulse-length command; 0 in IDLE.
- `m3cycleDone`  out  1: one-clock pulse when `sgStep` wraps from stepMax to 0.

## Operation
- **States:** IDLE, RUN, STOP. Encoding is free.
- **Reset** (async, immediate): state=IDLE, `m3cnt`=0, `sgStep`=15, `plLen`=0. All strobes, `pwmActive1` and `m3cycleDone` are 0. The shadow registers `len`, `smax` and `tgt` are cleared to 4, 0 and 0.
- **IDLE:** `m3cnt` holds at 0 and no strobes fire. When `m3r_run`=1 at a clock edge, the block moves to RUN and, on that same edge, sets:
  - `m3cnt`=0 and `sgStep`=0;
  - shadow `len`, `smax`, `tgt` and `ramp` latched from the clamped `m3r_*` values;
  - `plLen` = ramp(0).
- **RUN / STOP counting:** `m3cnt` increments each clock. On the clock where `m3cnt`==len-1 (a wrap), the following happen together:
  - `m3cnt` returns to 0;
  - all shadows are relatched from `m3r_*`;
  - `plLen` = ramp(`plLen`), computed with the *new* `tgt` and `ramp`;
  - `sgStep` = (`sgStep`==smax) ? 0 : `sgStep`+1.
- **`m3cycleDone`:** registered. It is 1 for the single clock after a wrap in which `sgStep` went from smax to 0.
- **ramp(p):**
  - if `ramp`==0: result is `tgt`;
  - if p<`tgt`: result is min(p+`ramp`, `tgt`), with a 17-bit sum so there is no overflow;
  - if p>`tgt`: result is max(p−`ramp`, `tgt`), with no underflow.
- **RUN → STOP:** when `m3r_run`=0 is sampled in RUN, the block enters STOP. The current step runs to completion with unchanged outputs.
- **STOP:**
  - At the wrap, the block enters IDLE: `sgStep`=15, `plLen`=0, `m3cnt`=0, and no shadow relatch.
  - If `m3r_run`=1 is sampled before the wrap, the block returns to RUN with no glitch. The wrap is then an ordinary RUN wrap.
- **Strobes:** combinational decode of the registered `m3cnt` and state, forced to 0 in IDLE.
  - With len=4, Last2 coincides with First2 (`m3cnt`=2?). No: with len=4, First2 is `m3cnt`=1 and Last2 is `m3cnt`=2, so all four strobes are distinct.
  - An `m3r_stepLen` change mid-step never truncates or extends the current step.
- **Config changes in IDLE** have no effect until the next start.

## Timing
- **Start latency:** `m3r_run` sampled high at edge N gives `pwmActive1`=1, `sgStep`=0 and `m3cntFirst1`=1 immediately after edge N.
- **Step period:** exactly `len` clocks.
  - `m3cntLast1` is high for exactly 1 clock per step.
  - `m3cntLast2` precedes it by 1 clock.
  - `m3cntFirst1` follows `m3cntLast1` by 1 clock.
- **`sgStep` / `plLen` updates:** change only on wrap edges, simultaneously with `m3cntFirst1` rising.
- **Stop latency:** at most one step. `pwmActive1` falls on the edge after the final `m3cntLast1`.
- **Reset mid-operation:** outputs go to their reset values asynchronously. After `rst` deasserts, the block is in IDLE; it restarts from `sgStep`=0 and `plLen`=0 only if `m3r_run`=1.

## Test plan
- **Basic run:** reset, then stepLen=10, stepMax=11, target=1000, ramp=0, run=1.
  - `sgStep` sequence 0,1,…,11,0 with 10 clocks per step.
  - `plLen`=1000 from the first clock.
  - `m3cycleDone` pulses once every 120 clocks.
  - Last2/Last1/First1/First2 occur at `m3cnt` 8, 9, 0, 1.
- **Ramp:** target=1000, ramp=300.
  - `plLen` goes 300, 600, 900, 1000, 1000 over successive steps.
  - Then target=400: `plLen` goes 700, 400, 400.
- **Clamps:**
  - stepLen=1 gives a 4-clock step.
  - stepMax=15 gives wrap at 14, so `sgStep` never reads 15 while running.
  - stepLen changed from 10 to 20 at `m3cnt`=3 leaves the current step at 10 clocks; the next step is 20.
- **Stop:** run=0 at `m3cnt`=2 of step 5.
  - Step 5 completes (`m3cntLast1` at `m3cnt`=9).
  - The next clock gives `sgStep`=15, `plLen`=0, `pwmActive1`=0, and no further strobes.
- **Stop abort:** run=0 then run=1 within the same step. There is no IDLE entry, and `sgStep` continues to 6 normally.
- **Async reset:** assert `rst` mid-step between clock edges.
  - Outputs go to their reset values immediately, with no clock edge required.
  - After release with run=1, the block restarts at `sgStep`=0 with ramped `plLen` from 0.

Source files
------------

// File: rtl/motoro3_step_scheduler.sv
// motoro3 commutation-step scheduler: step sub-counter, boundary strobes,
// commutation index and ramped pulse length for the PWM generator.
// Ports:
//   clk, rst (async, active-high); m3r_* run/config inputs;
//   pwmActive1, m3cnt, m3cntFirst1/2, m3cntLast2/1, sgStep, plLen,
//   m3cycleDone outputs. State updates on the falling clock edge.
module motoro3_step_scheduler #(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m3r_run,
  input  logic [CNT_W-1:0] m3r_stepLen,
  input  logic [3:0]       m3r_stepMax,
  input  logic [15:0]      m3r_plLenTarget,
  input  logic [15:0]      m3r_plLenRamp,
  output logic             pwmActive1,
  output logic [CNT_W-1:0] m3cnt,
  output logic             m3cntFirst1,
  output logic             m3cntFirst2,
  output logic             m3cntLast2,
  output logic             m3cntLast1,
  output logic [3:0]       sgStep,
  output logic [15:0]      plLen,
  output logic             m3cycleDone
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       step_q, step_d;
  logic [15:0]      pl_q, pl_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [3:0]       smax_q, smax_d;
  logic [15:0]      tgt_q, tgt_d;
  logic [15:0]      ramp_q, ramp_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] len_in;
  logic [3:0]       smax_in;
  logic             active;
  logic             last;
  logic             wrap;

  // 15 is reserved as the idle marker, so the step index tops out at 14.
  assign len_in  = (m3r_stepLen < CNT_W'(4)) ? CNT_W'(4) : m3r_stepLen;
  assign smax_in = (m3r_stepMax >= 4'd14) ? 4'd14 : m3r_stepMax;

  assign active = (state_q != ST_IDLE);
  assign last   = (cnt_q == len_q - CNT_W'(1));
  assign wrap   = active && last;

  function automatic logic [15:0] ramp_f(
    input logic [15:0] p,
    input logic [15:0] t,
    input logic [15:0] r
  );
    logic [16:0] sum;
    logic [15:0] res;
    sum = {1'b0, p} + {1'b0, r};
    res = p;
    if (r == 16'd0) begin
      res = t;
    end else if (p < t) begin
      res = (sum > {1'b0, t}) ? t : sum[15:0];
    end else if (p > t) begin
      res = (r >= (p - t)) ? t : (p - r);
    end
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    pl_d    = pl_q;
    len_d   = len_q;
    smax_d  = smax_q;
    tgt_d   = tgt_q;
    ramp_d  = ramp_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (m3r_run) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          step_d  = 4'd0;
          len_d   = len_in;
          smax_d  = smax_in;
          tgt_d   = m3r_plLenTarget;
          ramp_d  = m3r_plLenRamp;
          pl_d    = ramp_f(16'd0, m3r_plLenTarget, m3r_plLenRamp);
        end
      end
      ST_RUN, ST_STOP: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = m3r_run ? ST_RUN : ST_STOP;
        if (wrap) begin
          cnt_d = '0;
          if (state_q == ST_STOP && !m3r_run) begin
            // Stop completes at the step boundary: no relatch.
            state_d = ST_IDLE;
            step_d  = 4'd15;
            pl_d    = 16'd0;
          end else begin
            len_d  = len_in;
            smax_d = smax_in;
            tgt_d  = m3r_plLenTarget;
            ramp_d = m3r_plLenRamp;
            pl_d   = ramp_f(pl_q, m3r_plLenTarget, m3r_plLenRamp);
            step_d = (step_q == smax_q) ? 4'd0 : step_q + 4'd1;
            done_d = (step_q == smax_q);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      step_q  <= 4'd15;
      pl_q    <= 16'd0;
      len_q   <= CNT_W'(4);
      smax_q  <= 4'd0;
      tgt_q   <= 16'd0;
      ramp_q  <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      pl_q    <= pl_d;
      len_q   <= len_d;
      smax_q  <= smax_d;
      tgt_q   <= tgt_d;
      ramp_q  <= ramp_d;
      done_q  <= done_d;
    end
  end

  assign pwmActive1  = active;
  assign m3cnt       = cnt_q;
  assign m3cntFirst1 = active && (cnt_q == '0);
  assign m3cntFirst2 = active && (cnt_q == CNT_W'(1));
  assign m3cntLast2  = active && (cnt_q == len_q - CNT_W'(2));
  assign m3cntLast1  = wrap;
  assign sgStep      = step_q;
  assign plLen       = pl_q;
  assign m3cycleDone = done_q;

endmodule

// File: tb/tb_motoro3_step_scheduler.sv
// Directed testbench for motoro3_step_scheduler.
// DUT updates on negedge; bench drives and samples just after posedge.
module tb_motoro3_step_scheduler;

  localparam int CNT_W = 25;

  logic             clk = 1'b1;
  logic             rst = 1'b1;
  logic             run = 1'b0;
  logic [CNT_W-1:0] step_len = 25'd10;
  logic [3:0]       step_max = 4'd11;
  logic [15:0]      tgt = 16'd0;
  logic [15:0]      ramp = 16'd0;

  logic             pwm_active;
  logic [CNT_W-1:0] cnt;
  logic             f1, f2, l2, l1;
  logic [3:0]       sg_step;
  logic [15:0]      pl_len;
  logic             cyc_done;

  int n_tests = 0;
  int n_fail  = 0;
  int pl_exp [0:7] = '{300, 600, 900, 1000, 1000, 700, 400, 400};

  always #50 clk = ~clk;

  motoro3_step_scheduler #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .m3r_run         (run),
    .m3r_stepLen     (step_len),
    .m3r_stepMax     (step_max),
    .m3r_plLenTarget (tgt),
    .m3r_plLenRamp   (ramp),
    .pwmActive1      (pwm_active),
    .m3cnt           (cnt),
    .m3cntFirst1     (f1),
    .m3cntFirst2     (f2),
    .m3cntLast2      (l2),
    .m3cntLast1      (l1),
    .sgStep          (sg_step),
    .plLen           (pl_len),
    .m3cycleDone     (cyc_done)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    run = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] strb(input logic a, b, c, d);
    return {28'd0, a, b, c, d};
  endfunction

  initial begin
    // Reset state
    tick(2);
    chk("rst_step", 32'(sg_step), 15);
    chk("rst_pl", 32'(pl_len), 0);
    chk("rst_act", 32'(pwm_active), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_strb", strb(l2, l1, f1, f2), 0);
    chk("rst_done", 32'(cyc_done), 0);
    rst = 1'b0;
    tick();
    chk("idle_step", 32'(sg_step), 15);

    // Basic run: len 10, 12 steps, ramp 0
    step_len = 25'd10;
    step_max = 4'd11;
    tgt = 16'd1000;
    ramp = 16'd0;
    run = 1'b1;
    tick();
    chk("start_act", 32'(pwm_active), 1);
    for (int k = 0; k < 125; k++) begin
      if (k > 0) tick();
      chk("basic_cnt", 32'(cnt), 32'(k % 10));
      chk("basic_step", 32'(sg_step), 32'((k / 10) % 12));
      chk("basic_strb", strb(l2, l1, f1, f2),
          strb(k % 10 == 8, k % 10 == 9, k % 10 == 0, k % 10 == 1));
      chk("basic_done", 32'(cyc_done), 32'(k > 0 && k % 120 == 0));
      chk("basic_pl", 32'(pl_len), 1000);
    end

    // Ramp up then down, len 4
    do_reset();
    step_len = 25'd4;
    tgt = 16'd1000;
    ramp = 16'd300;
    run = 1'b1;
    tick();
    chk("ramp_0", 32'(pl_len), 300);
    chk("ramp_len4", strb(l2, l1, f1, f2), strb(0, 0, 1, 0));
    for (int i = 1; i < 8; i++) begin
      tick(3);
      chk("ramp_hold", 32'(pl_len), 32'(pl_exp[i-1]));
      tick();
      chk("ramp", 32'(pl_len), 32'(pl_exp[i]));
      if (i == 4) tgt = 16'd400;
    end

    // Clamps: stepLen 1 -> 4 clocks, stepMax 15 -> 14
    do_reset();
    step_len = 25'd1;
    step_max = 4'd15;
    tgt = 16'd5;
    ramp = 16'd0;
    run = 1'b1;
    tick();
    tick(2);
    chk("clamp_l2", strb(l2, l1, f1, f2), strb(1, 0, 0, 0));
    tick();
    chk("clamp_l1", strb(l2, l1, f1, f2), strb(0, 1, 0, 0));
    for (int k = 4; k <= 64; k += 4) begin
      if (k > 4) tick(4);
      else tick();
      chk("clamp_step", 32'(sg_step), 32'((k / 4) % 15));
      chk("clamp_cnt", 32'(cnt), 0);
    end

    // stepLen change mid-step
    do_reset();
    step_len = 25'd10;
    step_max = 4'd11;
    run = 1'b1;
    tick();
    tick(3);
    step_len = 25'd20;
    tick(6);
    chk("len_old_l1", 32'(l1), 1);
    chk("len_old_cnt", 32'(cnt), 9);
    tick();
    chk("len_wrap", 32'(sg_step), 1);
    tick(18);
    chk("len_new_l2", strb(l2, l1, f1, f2), strb(1, 0, 0, 0));
    tick();
    chk("len_new_l1", 32'(l1), 1);
    tick();
    chk("len_new_wrap", 32'(sg_step), 2);
    chk("len_new_cnt", 32'(cnt), 0);

    // Stop in step 5
    do_reset();
    step_len = 25'd10;
    tgt = 16'd1000;
    run = 1'b1;
    tick();
    tick(52);
    chk("stop_pre", 32'({sg_step, cnt[7:0]}), 32'({4'd5, 8'd2}));
    run = 1'b0;
    tick(7);
    chk("stop_l1", 32'(l1), 1);
    chk("stop_act", 32'(pwm_active), 1);
    chk("stop_pl", 32'(pl_len), 1000);
    tick();
    chk("stop_step", 32'(sg_step), 15);
    chk("stop_plz", 32'(pl_len), 0);
    chk("stop_actz", 32'(pwm_active), 0);
    chk("stop_strb", strb(l2, l1, f1, f2), 0);
    tick(5);
    chk("stop_idle", strb(l2, l1, f1, f2), 0);
    chk("stop_cnt", 32'(cnt), 0);

    // Stop abort within step 5
    run = 1'b1;
    tick();
    tick(52);
    run = 1'b0;
    tick(2);
    run = 1'b1;
    tick(5);
    chk("abort_l1", 32'(l1), 1);
    tick();
    chk("abort_step", 32'(sg_step), 6);
    chk("abort_act", 32'(pwm_active), 1);

    // Async reset between edges
    tick(3);
    #10;
    rst = 1'b1;
    #1;
    chk("arst_step", 32'(sg_step), 15);
    chk("arst_pl", 32'(pl_len), 0);
    chk("arst_act", 32'(pwm_active), 0);
    chk("arst_cnt", 32'(cnt), 0);
    tgt = 16'd1000;
    ramp = 16'd300;
    run = 1'b1;
    @(posedge clk);
    rst = 1'b0;
    tick();
    chk("arst_restart", 32'(sg_step), 0);
    chk("arst_pl0", 32'(pl_len), 300);
    chk("arst_f1", 32'(f1), 1);
    tick(10);
    chk("arst_step1", 32'(sg_step), 1);
    chk("arst_pl1", 32'(pl_len), 600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
